// File: rtl/wide_compare_seq.sv
// Multi-cycle W-bit magnitude comparator that walks N-bit chunks MSB-first through one shared slice.
// Optional macro WIDE_CMP_SIGNED_EN: treat operands as two's complement (top chunk sign bit inverted).
module wide_compare_seq #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         busy,
  output logic         done,
  output logic         L,
  output logic         E,
  output logic         G
);

  localparam int CHUNKS = W / N;
  localparam int IDXW   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(CHUNKS - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CMP  = 1'b1
  } state_t;

  state_t          r_state;
  logic [IDXW-1:0] r_idx;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_busy;
  logic            r_done;
  logic            r_l;
  logic            r_e;
  logic            r_g;

  logic [N-1:0]    w_a_chunk;
  logic [N-1:0]    w_b_chunk;
  logic [N-1:0]    w_a_slice;
  logic [N-1:0]    w_b_slice;
  logic            w_lt;
  logic            w_eq;
  logic            w_gt;

  assign w_a_chunk = r_a[int'(r_idx)*N +: N];
  assign w_b_chunk = r_b[int'(r_idx)*N +: N];

`ifdef WIDE_CMP_SIGNED_EN
  // Flipping the sign bit of the top chunk maps two's complement order onto unsigned order.
  logic         w_top;
  logic [N-1:0] w_sign_mask;
  assign w_top       = (r_idx == IDX_TOP);
  assign w_sign_mask = N'(w_top) << (N - 1);
  assign w_a_slice   = w_a_chunk ^ w_sign_mask;
  assign w_b_slice   = w_b_chunk ^ w_sign_mask;
`else
  assign w_a_slice   = w_a_chunk;
  assign w_b_slice   = w_b_chunk;
`endif

  comparator #(.N(N)) u_slice (
    .i_a  (w_a_slice),
    .i_b  (w_b_slice),
    .o_lt (w_lt),
    .o_eq (w_eq),
    .o_gt (w_gt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_l     <= 1'b0;
      r_e     <= 1'b0;
      r_g     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_idx   <= IDX_TOP;
            r_busy  <= 1'b1;
            r_state <= S_CMP;
          end
        end
        S_CMP: begin
          if (!w_eq) begin
            r_l     <= w_lt;
            r_e     <= 1'b0;
            r_g     <= w_gt;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_idx == '0) begin
            r_l     <= 1'b0;
            r_e     <= 1'b1;
            r_g     <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_idx   <= r_idx - IDXW'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign L    = r_l;
  assign E    = r_e;
  assign G    = r_g;

endmodule

// N-bit unsigned magnitude slice, purely combinational.
module comparator #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic         o_lt,
  output logic         o_eq,
  output logic         o_gt
);

  assign o_lt = (i_a <  i_b);
  assign o_eq = (i_a == i_b);
  assign o_gt = (i_a >  i_b);

endmodule

// File: tb/tb_wide_compare_seq.sv
// Randomized and directed self-checking bench for wide_compare_seq (N=4, W=16).
module tb_wide_compare_seq;

  localparam int N      = 4;
  localparam int W      = 16;
  localparam int CHUNKS = W / N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic         L;
  logic         E;
  logic         G;

  int n_checks = 0;
  int n_fail   = 0;

  wide_compare_seq #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .L     (L),
    .E     (E),
    .G     (G)
  );

  always #5 clk = ~clk;

  // Cycle (counted from the accepting edge) in which done is expected.
  function automatic int model_done_cycle(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] ca;
    logic [W-1:0] cb;
    for (int i = CHUNKS - 1; i >= 0; i--) begin
      ca = (a >> (i * N)) & ((1 << N) - 1);
      cb = (b >> (i * N)) & ((1 << N) - 1);
      if (ca != cb) return CHUNKS - i + 1;
    end
    return CHUNKS + 1;
  endfunction

  function automatic logic [2:0] model_flags(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef WIDE_CMP_SIGNED_EN
    if ($signed(a) < $signed(b)) return 3'b100;
    if ($signed(a) > $signed(b)) return 3'b001;
`else
    if (a < b) return 3'b100;
    if (a > b) return 3'b001;
`endif
    return 3'b010;
  endfunction

  // Launch one compare and observe it; comparisons are made by the callers.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int dcyc, output int bcnt, output logic [2:0] fl,
                        output logic d_after, output logic [2:0] fl_after);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk);
    dcyc = -1; bcnt = 0; fl = 3'bxxx;
    for (int c = 1; c <= CHUNKS + 8; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) begin
        dcyc = c;
        fl   = {L, E, G};
        break;
      end
      if (busy === 1'b1) bcnt++;
    end
    @(negedge clk);
    d_after  = done;
    fl_after = {L, E, G};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, L, E, G} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 00000", {busy, done, L, E, G});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, L, E, G} !== 5'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b required 00000", {busy, done, L, E, G});
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [5];
    logic [W-1:0] vb [5];
    int           vd [5];
    logic [2:0]   vf [5];
    int dcyc, bcnt;
    logic [2:0] fl, fla;
    logic da;
    va[0] = 16'h1234; vb[0] = 16'h1234; vd[0] = 5; vf[0] = 3'b010;
    va[1] = 16'h8000; vb[1] = 16'h7FFF; vd[1] = 2;
    va[2] = 16'h12A4; vb[2] = 16'h12B0; vd[2] = 4; vf[2] = 3'b100;
    va[3] = 16'hFFFF; vb[3] = 16'h0001; vd[3] = 2;
    va[4] = 16'h0000; vb[4] = 16'h0000; vd[4] = 5; vf[4] = 3'b010;
`ifdef WIDE_CMP_SIGNED_EN
    vf[1] = 3'b100; vf[3] = 3'b100;
`else
    vf[1] = 3'b001; vf[3] = 3'b001;
`endif
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], dcyc, bcnt, fl, da, fla);
      n_checks++;
      if (dcyc !== vd[i]) begin
        n_fail++;
        $display("FAIL dir%0d_latency: got cycle %0d required %0d", i, dcyc, vd[i]);
      end
      n_checks++;
      if (fl !== vf[i]) begin
        n_fail++;
        $display("FAIL dir%0d_flags: got LEG=%b required %b", i, fl, vf[i]);
      end
      n_checks++;
      if (bcnt !== vd[i] - 1) begin
        n_fail++;
        $display("FAIL dir%0d_busy_cycles: got %0d required %0d", i, bcnt, vd[i] - 1);
      end
      n_checks++;
      if (da !== 1'b0 || fla !== vf[i]) begin
        n_fail++;
        $display("FAIL dir%0d_pulse_hold: got done=%b LEG=%b required done=0 LEG=%b", i, da, fla, vf[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int dcyc;
    logic [2:0] fl;
    @(negedge clk);
    A = 16'h1234; B = 16'h1234; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    A = 16'hFFFF; B = 16'h0001; start = 1'b1;
    @(negedge clk); start = 1'b0;
    dcyc = -1; fl = 3'bxxx;
    for (int c = 3; c <= 12; c++) begin
      if (done === 1'b1) begin
        dcyc = c; fl = {L, E, G};
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (dcyc !== 5 || fl !== 3'b010) begin
      n_fail++;
      $display("FAIL ignore_start: got done cycle %0d LEG=%b required cycle 5 LEG=010", dcyc, fl);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_start_no_relaunch: got busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    A = 16'h0001; B = 16'h0002; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, L, E, G} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: got %b required 00000", {busy, done, L, E, G});
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0 || {L, E, G} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid_abort: got %0d busy/done cycles LEG=%b required 0 LEG=000", seen, {L, E, G});
    end
  endtask

  task automatic test_back_to_back();
    int first, second;
    logic [2:0] f1, f2;
    logic busy_next;
    @(negedge clk);
    A = 16'h12A4; B = 16'h12B0; start = 1'b1;
    @(posedge clk);
    first = -1; f1 = 3'bxxx;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        first = c; f1 = {L, E, G};
        A = 16'h0000; B = 16'h0000;
        break;
      end
    end
    @(negedge clk);
    start = 1'b0;
    busy_next = busy;
    second = -1; f2 = 3'bxxx;
    for (int c = 1; c <= 12; c++) begin
      if (done === 1'b1) begin
        second = c; f2 = {L, E, G};
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (first !== 4 || f1 !== 3'b100) begin
      n_fail++;
      $display("FAIL b2b_first: got cycle %0d LEG=%b required cycle 4 LEG=100", first, f1);
    end
    n_checks++;
    if (busy_next !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_no_bubble: got busy=%b required 1", busy_next);
    end
    n_checks++;
    if (second !== 5 || f2 !== 3'b010) begin
      n_fail++;
      $display("FAIL b2b_second: got %0d cycles later LEG=%b required 5 LEG=010", second, f2);
    end
  endtask

  task automatic test_random();
    int dcyc, bcnt, ed;
    logic [2:0] fl, fla, ef;
    logic da;
    logic [W-1:0] a, b;
    for (int i = 0; i < 150; i++) begin
      a = W'($urandom);
      case ($urandom_range(0, 3))
        0: b = W'($urandom);
        1: b = a;
        2: b = a ^ (W'(1) << $urandom_range(0, W - 1));
        default: b = {a[W-1:N], N'($urandom)};
      endcase
      ed = model_done_cycle(a, b);
      ef = model_flags(a, b);
      run_op(a, b, dcyc, bcnt, fl, da, fla);
      n_checks++;
      if (dcyc !== ed || fl !== ef || bcnt !== ed - 1 || da !== 1'b0 || fla !== ef) begin
        n_fail++;
        $display("FAIL random%0d A=%h B=%h: got cycle=%0d busy=%0d LEG=%b next_done=%b held=%b required cycle=%0d busy=%0d LEG=%b",
                 i, a, b, dcyc, bcnt, fl, da, fla, ed, ed - 1, ef);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
